// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide scheduler.
package muldiv_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_MUL_LAT = 2;

    // LO is filled with this bit on a short-circuited divide by zero.
    localparam logic DIV0_LO_BIT = 1'b1;

    typedef enum logic [2:0] {
        OpNop   = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMulWait = 2'd1,
        StDivWait = 2'd2,
        StDone    = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_sched_if.sv
// EX request, mul/div unit and HI/LO signals of the muldiv scheduler.
// Names carry the scheduler's view: i_ driven into it, o_ driven by it.
interface muldiv_sched_if import muldiv_pkg::*; #(
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic                  i_flush;
    logic                  i_req_valid;
    md_op_e                i_req_op;
    logic [DATA_W-1:0]     i_src_a;
    logic [DATA_W-1:0]     i_src_b;
    logic                  o_mul_signed;
    logic [DATA_W-1:0]     o_mul_ina;
    logic [DATA_W-1:0]     o_mul_inb;
    logic [2*DATA_W-1:0]   i_mul_result;
    logic                  o_div_start;
    logic                  o_div_annul;
    logic                  o_div_signed;
    logic [DATA_W-1:0]     o_div_opa;
    logic [DATA_W-1:0]     o_div_opb;
    logic                  i_div_ready;
    logic [2*DATA_W-1:0]   i_div_result;
    logic                  o_stallreq;
    logic [DATA_W-1:0]     o_hi;
    logic [DATA_W-1:0]     o_lo;
    logic                  o_busy;

    modport master (
        output i_flush, i_req_valid, i_req_op, i_src_a, i_src_b,
        output i_mul_result, i_div_ready, i_div_result,
        input  o_mul_signed, o_mul_ina, o_mul_inb,
        input  o_div_start, o_div_annul, o_div_signed, o_div_opa, o_div_opb,
        input  o_stallreq, o_hi, o_lo, o_busy
    );

    modport slave (
        input  i_flush, i_req_valid, i_req_op, i_src_a, i_src_b,
        input  i_mul_result, i_div_ready, i_div_result,
        output o_mul_signed, o_mul_ina, o_mul_inb,
        output o_div_start, o_div_annul, o_div_signed, o_div_opa, o_div_opb,
        output o_stallreq, o_hi, o_lo, o_busy
    );

endinterface

// File: rtl/muldiv_sched.sv
// EX-stage MULT/DIV/MTHI/MTLO sequencer owning HI/LO.
// MULDIV_DIV0_FAST_EN: divide by zero bypasses the divider (HI=src_a, LO=all ones).
module muldiv_sched import muldiv_pkg::*; #(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    muldiv_sched_if.slave md
);

    localparam int unsigned     CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    md_state_e         r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [DATA_W-1:0] r_hi, w_hi_next;
    logic [DATA_W-1:0] r_lo, w_lo_next;
    logic              w_stallreq, w_div_start, w_div_annul;
    logic              w_is_mul, w_is_div, w_div0_fast;

    assign w_is_mul = (md.i_req_op == OpMult) || (md.i_req_op == OpMultu);
    assign w_is_div = (md.i_req_op == OpDiv)  || (md.i_req_op == OpDivu);

`ifdef MULDIV_DIV0_FAST_EN
    assign w_div0_fast = (md.i_src_b == '0);
`else
    assign w_div0_fast = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_stallreq   = 1'b0;
        w_div_start  = 1'b0;
        w_div_annul  = 1'b0;
        if (md.i_flush) begin
            // Flush wins over a same-cycle div_ready or mul completion.
            w_state_next = StIdle;
            w_div_annul  = (r_state == StDivWait);
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (md.i_req_valid) begin
                        if (w_is_mul) begin
                            w_stallreq   = 1'b1;
                            w_cnt_next   = CNT_INIT;
                            w_state_next = StMulWait;
                        end else if (w_is_div && w_div0_fast) begin
                            w_stallreq   = 1'b1;
                            w_hi_next    = md.i_src_a;
                            w_lo_next    = {DATA_W{DIV0_LO_BIT}};
                            w_state_next = StDone;
                        end else if (w_is_div) begin
                            w_stallreq   = 1'b1;
                            w_div_start  = 1'b1;
                            w_state_next = StDivWait;
                        end else if (md.i_req_op == OpMthi) begin
                            w_hi_next = md.i_src_a;
                        end else if (md.i_req_op == OpMtlo) begin
                            w_lo_next = md.i_src_a;
                        end
                    end
                end
                StMulWait: begin
                    w_stallreq = 1'b1;
                    if (r_cnt == '0) begin
                        w_hi_next    = md.i_mul_result[2*DATA_W-1:DATA_W];
                        w_lo_next    = md.i_mul_result[DATA_W-1:0];
                        w_state_next = StDone;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                StDivWait: begin
                    w_stallreq  = 1'b1;
                    w_div_start = 1'b1;
                    if (md.i_div_ready) begin
                        w_hi_next    = md.i_div_result[2*DATA_W-1:DATA_W];
                        w_lo_next    = md.i_div_result[DATA_W-1:0];
                        w_state_next = StDone;
                    end
                end
                StDone: begin
                    // EX advances this cycle; a still-high req_valid is the finished op.
                    w_state_next = StIdle;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    assign md.o_mul_signed = (md.i_req_op == OpMult);
    assign md.o_mul_ina    = md.i_src_a;
    assign md.o_mul_inb    = md.i_src_b;
    assign md.o_div_signed = (md.i_req_op == OpDiv);
    assign md.o_div_opa    = md.i_src_a;
    assign md.o_div_opb    = md.i_src_b;
    assign md.o_div_start  = w_div_start;
    assign md.o_div_annul  = w_div_annul;
    assign md.o_stallreq   = w_stallreq;
    assign md.o_hi         = r_hi;
    assign md.o_lo         = r_lo;
    assign md.o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched with behavioural mul (fixed latency) and div (driven pulse).
module tb_muldiv_sched;
    import muldiv_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MUL_LAT = 2;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    muldiv_sched_if #(.DATA_W(DATA_W)) md ();

    muldiv_sched #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .md       (md)
    );

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic signed [63:0] sa, sbv;
        if (sgn) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
            return sa * sbv;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic signed [31:0] q, r;
        if (b == '0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    // MUL_LAT-stage multiplier model
    logic [63:0] mul_p0, mul_p1;
    always_ff @(posedge clk) begin
        mul_p0 <= mul_ref(md.o_mul_ina, md.o_mul_inb, md.o_mul_signed);
        mul_p1 <= mul_p0;
    end
    assign md.i_mul_result = mul_p1;

    task automatic idle_inputs();
        md.i_flush      = 1'b0;
        md.i_req_valid  = 1'b0;
        md.i_req_op     = OpNop;
        md.i_src_a      = '0;
        md.i_src_b      = '0;
        md.i_div_ready  = 1'b0;
        md.i_div_result = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (md.o_hi !== 32'h0 || md.o_lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h expected 0_0", md.o_hi, md.o_lo);
        end
        checks++;
        if ({md.o_busy, md.o_stallreq, md.o_div_start, md.o_div_annul} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 0000",
                     {md.o_busy, md.o_stallreq, md.o_div_start, md.o_div_annul});
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Issue one op, supply div_ready at cycle div_lat, check stall/start counts and HI/LO.
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input int div_lat, input int exp_stall, input int exp_start,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input string name);
        int   stall_cnt, start_cnt, cyc;
        logic is_div, exp_sgn;
        exp_t e;
        is_div  = (op == OpDiv) || (op == OpDivu);
        exp_sgn = (op == OpMult) || (op == OpDiv);
        @(negedge clk);
        md.i_req_valid = 1'b1;
        md.i_req_op    = op;
        md.i_src_a     = a;
        md.i_src_b     = b;
        sb.push_back('{name, e_hi, e_lo});
        #1;
        checks++;
        if ((is_div ? md.o_div_signed : md.o_mul_signed) !== exp_sgn) begin
            errors++;
            $display("FAIL %s_signed: got %b expected %b", name,
                     is_div ? md.o_div_signed : md.o_mul_signed, exp_sgn);
        end
        stall_cnt = 0;
        start_cnt = 0;
        cyc       = 0;
        while (md.o_stallreq && cyc < 200) begin
            stall_cnt++;
            if (md.o_div_start && !md.i_div_ready) start_cnt++;
            @(negedge clk);
            cyc++;
            md.i_div_ready  = (cyc == div_lat);
            md.i_div_result = div_ref(md.o_div_opa, md.o_div_opb, md.o_div_signed);
            #1;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL %s_timeout: stallreq still high after %0d cycles, expected low", name,
                     cyc);
        end
        checks++;
        if (stall_cnt != exp_stall) begin
            errors++;
            $display("FAIL %s_stall: got %0d cycles expected %0d", name, stall_cnt, exp_stall);
        end
        checks++;
        if (start_cnt != exp_start) begin
            errors++;
            $display("FAIL %s_div_start: got %0d cycles expected %0d", name, start_cnt,
                     exp_start);
        end
        checks++;
        if (md.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_busy: got %b expected 1", name, md.o_busy);
        end
        e = sb.pop_front();
        exp_hi = e.hi;
        exp_lo = e.lo;
        checks++;
        if (md.o_hi !== e.hi || md.o_lo !== e.lo) begin
            errors++;
            $display("FAIL %s_hilo: got %h_%h expected %h_%h", e.name, md.o_hi, md.o_lo,
                     e.hi, e.lo);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (md.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got busy %b expected 0", name, md.o_busy);
        end
    endtask

    task automatic test_mt_back_to_back();
        exp_t e;
        @(negedge clk);
        md.i_req_valid = 1'b1;
        md.i_req_op    = OpMthi;
        md.i_src_a     = 32'h1234_5678;
        sb.push_back('{"mthi", 32'h1234_5678, exp_lo});
        #1;
        checks++;
        if (md.o_stallreq !== 1'b0) begin
            errors++;
            $display("FAIL mthi_stall: got %b expected 0", md.o_stallreq);
        end
        @(negedge clk);
        md.i_req_op = OpMtlo;
        md.i_src_a  = 32'h9ABC_DEF0;
        e = sb.pop_front();
        sb.push_back('{"mtlo", e.hi, 32'h9ABC_DEF0});
        #1;
        checks++;
        if (md.o_hi !== e.hi || md.o_lo !== e.lo || md.o_stallreq !== 1'b0) begin
            errors++;
            $display("FAIL %s_hilo: got %h_%h stall %b expected %h_%h stall 0", e.name,
                     md.o_hi, md.o_lo, md.o_stallreq, e.hi, e.lo);
        end
        @(negedge clk);
        idle_inputs();
        e = sb.pop_front();
        exp_hi = e.hi;
        exp_lo = e.lo;
        #1;
        checks++;
        if (md.o_hi !== e.hi || md.o_lo !== e.lo || md.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_hilo: got %h_%h busy %b expected %h_%h busy 0", e.name,
                     md.o_hi, md.o_lo, md.o_busy, e.hi, e.lo);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        md.i_req_valid = 1'b1;
        md.i_req_op    = OpDivu;
        md.i_src_a     = 32'd100;
        md.i_src_b     = 32'd7;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (md.o_stallreq !== 1'b1 || md.o_div_start !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait: got stall %b start %b expected 1 1", md.o_stallreq,
                     md.o_div_start);
        end
        @(negedge clk);
        md.i_flush      = 1'b1;
        md.i_div_ready  = 1'b1;
        md.i_div_result = 64'hDEAD_BEEF_CAFE_F00D;
        #1;
        checks++;
        if (md.o_div_annul !== 1'b1 || md.o_stallreq !== 1'b0 || md.o_div_start !== 1'b0) begin
            errors++;
            $display("FAIL flush_annul: got annul %b stall %b start %b expected 1 0 0",
                     md.o_div_annul, md.o_stallreq, md.o_div_start);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (md.o_busy !== 1'b0 || md.o_div_annul !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got busy %b annul %b expected 0 0", md.o_busy,
                     md.o_div_annul);
        end
        checks++;
        if (md.o_hi !== exp_hi || md.o_lo !== exp_lo) begin
            errors++;
            $display("FAIL flush_hilo: got %h_%h expected %h_%h", md.o_hi, md.o_lo, exp_hi,
                     exp_lo);
        end
    endtask

    task automatic test_div0();
`ifdef MULDIV_DIV0_FAST_EN
        run_op(OpDiv, 32'd10, 32'd0, -1, 1, 0, 32'h0000_000A, 32'hFFFF_FFFF, "div0_fast");
`else
        @(negedge clk);
        md.i_req_valid = 1'b1;
        md.i_req_op    = OpDiv;
        md.i_src_a     = 32'd10;
        md.i_src_b     = 32'd0;
        #1;
        checks++;
        if (md.o_div_start !== 1'b1 || md.o_stallreq !== 1'b1) begin
            errors++;
            $display("FAIL div0_start: got start %b stall %b expected 1 1", md.o_div_start,
                     md.o_stallreq);
        end
        @(negedge clk);
        md.i_flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (md.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL div0_cleanup: got busy %b expected 0", md.o_busy);
        end
`endif
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        md.i_req_valid = 1'b1;
        md.i_req_op    = OpMult;
        md.i_src_a     = 32'd7;
        md.i_src_b     = 32'd9;
        @(negedge clk);
        #1;
        checks++;
        if (md.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy: got %b expected 1", md.o_busy);
        end
        idle_inputs();
        resetn = 1'b0;
        #1;
        checks++;
        if (md.o_hi !== 32'h0 || md.o_lo !== 32'h0 || md.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_hilo: got %h_%h busy %b expected 0_0 busy 0", md.o_hi,
                     md.o_lo, md.o_busy);
        end
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        run_op(OpMult, 32'hFFFF_FFFD, 32'd5, -1, 3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult");
        run_op(OpMultu, 32'hFFFF_FFFF, 32'd2, -1, 3, 0, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 33, 34, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        test_mt_back_to_back();
        test_flush();
        test_div0();
        run_op(OpMult, 32'h0001_0000, 32'h0001_0000, -1, 3, 0, 32'h0000_0001, 32'h0, "mult_b2b");
        run_op(OpDivu, 32'd100, 32'd7, 4, 5, 4, 32'd2, 32'd14, "divu_b2b");
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
